// File: rtl/mcu_spi_bridge.sv
// mcu_spi_bridge
//   MCU-side SPI slave (mode 0, MSB first) that turns each serial frame into a single-beat
//   bus cycle on the internal MCU register bus and returns read data over MISO.
//   Frame: CMD[7:0], ADDR[ADDR_W-1:0], DATA[31:0]. CMD[7]=1 write, CMD[3:0] byte enables.
//
// Ports
//   clk, rst    system clock, synchronous active-high reset
//   spi_sck     SPI clock from MCU (asynchronous, <= clk/4)
//   spi_ss_n    SPI select, active low (asynchronous)
//   spi_mosi    SPI data in
//   spi_miso    SPI data out, 0 outside the read-data phase
//   bus_ce      bus cycle strobe
//   bus_we      byte write enables, nonzero only during a write strobe
//   bus_addr    byte address (held after the strobe until the next access or idle)
//   bus_dato    write data (held likewise)
//   bus_dati    read data from the bus mux
//   busy        high while a frame is in progress
module mcu_spi_bridge #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              bus_ce,
    output logic [3:0]        bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_dato,
    input  logic [31:0]       bus_dati,
    output logic              busy
);

    // Receive shift register needs one bit less than the widest field: the newest bit
    // comes straight from the synchronizer.
    localparam int unsigned SR_W  = (ADDR_W > 32) ? ADDR_W : 32;
    localparam int unsigned CNT_W = $clog2(SR_W + 1);

    localparam logic [CNT_W-1:0] CmdLast  = CNT_W'(7);
    localparam logic [CNT_W-1:0] AddrLast = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DataLast = CNT_W'(31);
    localparam logic [CNT_W-1:0] LatLast  = CNT_W'(RD_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StRdAcc,
        StRdShift,
        StWrData,
        StWrAcc,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sck_sync_q, ss_sync_q, mosi_sync_q;
    logic              sck_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-2:0]   rx_q, rx_d;
    logic [31:0]       tx_q, tx_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [3:0]        cmd_be_q, cmd_be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dato_q, dato_d;

    logic              sck_s, ss_n_s, mosi_s;
    logic              sck_rise, sck_fall;
    logic [SR_W-1:0]   rx_shift;

    assign sck_s    = sck_sync_q[1];
    assign ss_n_s   = ss_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign rx_shift = {rx_q, mosi_s};

    assign bus_addr = addr_q;
    assign bus_dato = dato_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= 2'b00;
            ss_sync_q   <= 2'b11;  // deselected, so reset never looks like a frame start
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            cmd_wr_q    <= 1'b0;
            cmd_be_q    <= '0;
            addr_q      <= '0;
            dato_q      <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_sck};
            ss_sync_q   <= {ss_sync_q[0], spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_be_q    <= cmd_be_d;
            addr_q      <= addr_d;
            dato_q      <= dato_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        cmd_wr_d = cmd_wr_q;
        cmd_be_d = cmd_be_q;
        addr_d   = addr_q;
        dato_d   = dato_q;
        bus_ce   = 1'b0;
        bus_we   = 4'h0;
        spi_miso = 1'b0;
        busy     = 1'b1;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (!ss_n_s) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (sck_rise) begin
                    rx_d = rx_shift[SR_W-2:0];
                    if (cnt_q == CmdLast) begin
                        cmd_wr_d = rx_shift[7];
                        cmd_be_d = rx_shift[3:0];
                        cnt_d    = '0;
                        state_d  = StAddr;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StAddr: begin
                if (sck_rise) begin
                    rx_d = rx_shift[SR_W-2:0];
                    if (cnt_q == AddrLast) begin
                        addr_d  = rx_shift[ADDR_W-1:0];
                        cnt_d   = '0;
                        state_d = cmd_wr_q ? StWrData : StRdAcc;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StRdAcc: begin
                // ce held for RD_LAT+1 clocks; cnt_q counts clocks here, SCK is ignored.
                bus_ce = 1'b1;
                if (cnt_q == LatLast) begin
                    tx_d    = bus_dati;
                    cnt_d   = '0;
                    state_d = StRdShift;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRdShift: begin
                spi_miso = tx_q[31];
                if (sck_rise) begin
                    if (cnt_q == DataLast) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall && (cnt_q != '0)) begin
                    // The trailing fall of the last address bit may land here; only
                    // falls after a data rise advance the shifter.
                    tx_d = {tx_q[30:0], 1'b0};
                end
            end
            StWrData: begin
                if (sck_rise) begin
                    rx_d = rx_shift[SR_W-2:0];
                    if (cnt_q == DataLast) begin
                        dato_d  = rx_shift[31:0];
                        cnt_d   = '0;
                        state_d = StWrAcc;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StWrAcc: begin
                bus_ce  = 1'b1;
                bus_we  = cmd_be_q;
                state_d = StDone;
            end
            StDone: begin
                busy = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Deselect ends the frame from any state; an in-flight read is dropped uncaptured.
        if ((state_q != StIdle) && ss_n_s) begin
            state_d = StIdle;
        end

        if (state_d == StIdle) begin
            cnt_d    = '0;
            rx_d     = '0;
            tx_d     = '0;
            cmd_wr_d = 1'b0;
            cmd_be_d = '0;
            addr_d   = '0;
            dato_d   = '0;
        end
    end

endmodule
